// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
// The master drives words in and observes the stream; the slave is the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 8
) ();
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] data_in;
  logic             data_out;
  logic             out_valid;
  logic             frame_start;
  logic             done;

  modport master (
    output load_valid, data_in,
    input  load_ready, data_out, out_valid, frame_start, done
  );

  modport slave (
    input  load_valid, data_in,
    output load_ready, data_out, out_valid, frame_start, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: one WIDTH-bit word per WIDTH cycles, MSB or LSB first,
// with frame_start/done strobes and gap-free reload on the last bit.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  piso_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;

  logic             w_shift;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_sreg_next;

  assign w_shift  = (r_state == S_SHIFT);
  assign w_last   = w_shift && (r_cnt == '0);
  assign w_ready  = !w_shift || w_last;
  assign w_accept = bus.load_valid && w_ready;

  // Zero fill keeps data_out low once the word has fully drained.
  assign w_sreg_next = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0}
                                 : {1'b0, r_sreg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_state <= S_SHIFT;
      r_sreg  <= bus.data_in;
      r_cnt   <= CNT_TOP;
    end else if (w_shift) begin
      if (r_cnt != '0) begin
        r_sreg <= w_sreg_next;
        r_cnt  <= r_cnt - 1'b1;
      end else begin
        r_sreg  <= '0;
        r_state <= S_IDLE;
      end
    end
  end

  assign bus.load_ready  = w_ready;
  assign bus.data_out    = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];
  assign bus.out_valid   = w_shift;
  assign bus.frame_start = w_shift && (r_cnt == CNT_TOP);
  assign bus.done        = w_last;
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (8/MSB, 8/LSB, 4/MSB) driven by directed steps,
// with expected bits queued at accept time and compared as each instance emits them.
module tb_piso_serializer;
  typedef struct packed {
    logic b;
    logic fs;
    logic dn;
    logic gapok;
  } exp_t;

  logic clk;
  logic reset;
  bit   mon_en;
  int   n_cmp;
  int   n_err;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  piso_serializer_if #(.WIDTH(8)) if0 ();
  piso_serializer_if #(.WIDTH(8)) if1 ();
  piso_serializer_if #(.WIDTH(4)) if2 ();

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qfront(input int d);
    case (d)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic exp_t qpop(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic qpush(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic logic rdy(input int d);
    case (d)
      0:       return if0.load_ready;
      1:       return if1.load_ready;
      default: return if2.load_ready;
    endcase
  endfunction

  task automatic drive(input int d, input logic lv, input logic [31:0] w);
    case (d)
      0:       begin if0.load_valid = lv; if0.data_in = w[7:0]; end
      1:       begin if1.load_valid = lv; if1.data_in = w[7:0]; end
      default: begin if2.load_valid = lv; if2.data_in = w[3:0]; end
    endcase
  endtask

  // Compare one cycle of a DUT's output against the head of its expected queue.
  task automatic mon(input int d, input logic ov, input logic dout, input logic fs,
                     input logic dn, input logic ready);
    exp_t  e;
    string t;
    t = $sformatf("dut%0d", d);
    if (ov) begin
      if (qsize(d) == 0) begin
        check({t, "_spurious_valid"}, ov, 1'b0);
      end else begin
        e = qpop(d);
        check({t, "_data_out"}, dout, e.b);
        check({t, "_frame_start"}, fs, e.fs);
        check({t, "_done"}, dn, e.dn);
        check({t, "_load_ready_busy"}, ready, e.dn);
      end
    end else begin
      check({t, "_idle_data_out"}, dout, 1'b0);
      check({t, "_idle_frame_start"}, fs, 1'b0);
      check({t, "_idle_done"}, dn, 1'b0);
      check({t, "_idle_load_ready"}, ready, 1'b1);
      if (qsize(d) != 0) begin
        e = qfront(d);
        if (!e.gapok) check({t, "_gap_in_stream"}, ov, 1'b1);
      end
    end
  endtask

  always @(negedge clk) if (mon_en) mon(0, if0.out_valid, if0.data_out, if0.frame_start, if0.done, if0.load_ready);
  always @(negedge clk) if (mon_en) mon(1, if1.out_valid, if1.data_out, if1.frame_start, if1.done, if1.load_ready);
  always @(negedge clk) if (mon_en) mon(2, if2.out_valid, if2.data_out, if2.frame_start, if2.done, if2.load_ready);

  // Present a word, wait for load_ready, queue its bit stream, and release after the accept edge.
  task automatic send(input int d, input logic [31:0] w, input bit bb);
    int   wd;
    bit   msb;
    int   to;
    exp_t e;
    wd = (d == 2) ? 4 : 8;
    msb = (d != 1);
    drive(d, 1'b1, w);
    to = 0;
    forever begin
      @(negedge clk);
      if (rdy(d)) break;
      to++;
      if (to > 64) begin
        check($sformatf("dut%0d_send_timeout", d), 1'b0, 1'b1);
        drive(d, 1'b0, 32'h0);
        return;
      end
    end
    for (int i = 0; i < wd; i++) begin
      e.b     = msb ? w[wd-1-i] : w[i];
      e.fs    = (i == 0);
      e.dn    = (i == wd - 1);
      e.gapok = (i == 0) && !bb;
      qpush(d, e);
    end
    @(posedge clk);
    #1;
    drive(d, 1'b0, 32'h0);
  endtask

  task automatic drain(input int d);
    int to;
    to = 0;
    while (qsize(d) != 0 && to < 100) begin
      @(posedge clk);
      to++;
    end
    if (to >= 100) check($sformatf("dut%0d_drain_timeout", d), 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    mon_en = 1'b0;
    reset  = 1'b1;
    drive(0, 1'b1, 32'hFF);
    drive(1, 1'b1, 32'hFF);
    drive(2, 1'b1, 32'hF);

    // Reset held two cycles with load_valid high: outputs idle, nothing captured.
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_load_ready", if0.load_ready, 1'b1);
      check("rst_data_out", if0.data_out, 1'b0);
      check("rst_out_valid", if0.out_valid, 1'b0);
      check("rst_frame_start", if0.frame_start, 1'b0);
      check("rst_done", if0.done, 1'b0);
      if (c == 0) @(posedge clk);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(0, 1'b0, 32'h0);
    drive(1, 1'b0, 32'h0);
    drive(2, 1'b0, 32'h0);
    @(negedge clk);
    check("post_rst_out_valid", if0.out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Single word, MSB first.
    send(0, 32'hB5, 1'b0);
    drain(0);

    // Back-to-back words with load_valid held high.
    send(0, 32'hA5, 1'b0);
    send(0, 32'h3C, 1'b1);
    drain(0);

    // LSB first, and the narrow instance.
    send(1, 32'hB5, 1'b0);
    drain(1);
    send(2, 32'hD, 1'b0);
    drain(2);

    // Load attempt while busy is ignored.
    send(0, 32'hFF, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    drive(0, 1'b1, 32'h00);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 32'h0);
    drain(0);

    // Mid-word reset drops the word; a later word goes out cleanly.
    send(0, 32'hF0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q0.delete();
    @(negedge clk);
    check("midrst_out_valid", if0.out_valid, 1'b0);
    check("midrst_data_out", if0.data_out, 1'b0);
    check("midrst_load_ready", if0.load_ready, 1'b1);
    @(posedge clk);
    #1;
    send(0, 32'h81, 1'b0);
    drain(0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
